// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and address constants for the OAM DMA controller.
// Imported by the controller and by anything that needs the system bus map.
package oam_dma_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      COPY
   } dma_state_t;

   localparam logic [15:0] OAM_BASE = 16'hFE00;
   localparam int          OAM_LEN  = 160;
   localparam logic [15:0] HRAM_LO  = 16'hFF80;
   localparam logic [15:0] HRAM_HI  = 16'hFFFE;
   localparam logic [15:0] REG_DMA  = 16'hFF46;

   // Echo RAM pages E0..FF alias WRAM C0..DF.
   function automatic logic [7:0] map_src_hi(input logic [7:0] page);
      return (page >= 8'hE0) ? page - 8'h20 : page;
   endfunction

   // Used by the system bus: only HRAM stays reachable while the copy owns the bus.
   function automatic logic cpu_blocked(input logic lock, input logic [15:0] addr);
      return lock && !((addr >= HRAM_LO) && (addr <= HRAM_HI));
   endfunction

   function automatic logic [15:0] oam_bus_addr(input logic [7:0] offset);
      return OAM_BASE + {8'h00, offset};
   endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the OAM DMA controller and the rest of the system.
// master = controller side, slave = CPU/memory/OAM side.
interface oam_dma_ctrl_if;

   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  reg_rdata;
   logic        src_rd;
   logic [15:0] src_addr;
   logic [7:0]  src_data;
   logic        oam_wr;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        dma_active;
   logic        cpu_bus_lock;

   modport master (
      input  cpu_addr, cpu_wr, cpu_wdata, src_data,
      output reg_rdata, src_rd, src_addr, oam_wr, oam_addr, oam_wdata,
      output dma_active, cpu_bus_lock
   );

   modport slave (
      output cpu_addr, cpu_wr, cpu_wdata, src_data,
      input  reg_rdata, src_rd, src_addr, oam_wr, oam_addr, oam_wdata,
      input  dma_active, cpu_bus_lock
   );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: an FF46 write copies OAM_LEN bytes from page src_hi into OAM,
// one byte per CYCLES_PER_BYTE clocks (read, capture, write, idle...).
module oam_dma_ctrl #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int START_DELAY     = 4,
   parameter int OAM_LEN         = oam_dma_ctrl_pkg::OAM_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   oam_dma_ctrl_if.master        bus
);

   import oam_dma_ctrl_pkg::*;

   localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
   localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   localparam logic [PW-1:0] PH_RD      = '0;
   localparam logic [PW-1:0] PH_CAP     = PW'(1);
   localparam logic [PW-1:0] PH_WR      = PW'(2);
   localparam logic [PW-1:0] PH_LAST    = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [DW-1:0] SETUP_LAST = DW'(START_DELAY - 1);
   localparam logic [7:0]    IDX_LAST   = 8'(OAM_LEN - 1);

   dma_state_t    state, state_n;
   logic [DW-1:0] dly, dly_n;
   logic [PW-1:0] phase, phase_n;
   logic [7:0]    idx, idx_n;
   logic          relock, relock_n;
   logic [7:0]    reg_q;
   logic [7:0]    src_hi;
   logic [7:0]    data_p1;
   logic          trigger;
   logic          rd, wr, capture, active, lock;

   assign trigger = bus.cpu_wr && (bus.cpu_addr == REG_DMA);

   always_comb begin
      state_n  = state;
      dly_n    = dly;
      phase_n  = phase;
      idx_n    = idx;
      relock_n = relock;
      active   = (state != IDLE);
      // A restart from a locked transfer keeps the lock through the new SETUP.
      lock     = (state == COPY) || ((state == SETUP) && relock);
      rd       = (state == COPY) && (phase == PH_RD);
      capture  = (state == COPY) && (phase == PH_CAP);
      wr       = (state == COPY) && (phase == PH_WR);

      unique case (state)
         IDLE: ;
         SETUP: begin
            if (dly == SETUP_LAST) begin
               state_n  = COPY;
               phase_n  = '0;
               idx_n    = '0;
               relock_n = 1'b0;
            end else begin
               dly_n = dly + 1'b1;
            end
         end
         COPY: begin
            if (phase == PH_LAST) begin
               phase_n = '0;
               if (idx == IDX_LAST) state_n = IDLE;
               else                 idx_n   = idx + 1'b1;
            end else begin
               phase_n = phase + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A trigger overrides everything, including the final-byte exit to IDLE.
      if (trigger) begin
         state_n  = SETUP;
         dly_n    = '0;
         phase_n  = '0;
         idx_n    = '0;
         relock_n = lock;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         dly    <= '0;
         phase  <= '0;
         idx    <= '0;
         relock <= 1'b0;
         reg_q  <= '0;
      end else begin
         state  <= state_n;
         dly    <= dly_n;
         phase  <= phase_n;
         idx    <= idx_n;
         relock <= relock_n;
         if (trigger) reg_q <= bus.cpu_wdata;
      end
   end

   // Capture stage: source byte arrives the clock after src_rd.
   always_ff @(posedge clk) begin
      if (trigger) src_hi  <= map_src_hi(bus.cpu_wdata);
      if (capture) data_p1 <= bus.src_data;
   end

   assign bus.reg_rdata    = reg_q;
   assign bus.src_rd       = rd;
   assign bus.src_addr     = rd ? {src_hi, idx} : 16'h0000;
   assign bus.oam_wr       = wr;
   assign bus.oam_addr     = wr ? idx : 8'h00;
   assign bus.oam_wdata    = wr ? data_p1 : 8'h00;
   assign bus.dma_active   = active;
   assign bus.cpu_bus_lock = lock;

endmodule
